// File: rtl/round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
//   Gives one of CHANNELS requesters exclusive ownership of a shared resource.
//   The arbitration is round-robin. The owner keeps the grant until it pulses
//   i_done or drops its request. All outputs come straight from flops, so no
//   input reaches an output through combinational logic.
//
//   Optional feature (compile-time macro ARB_TIMEOUT_EN):
//     When it is defined, a hold counter forces a release after TIMEOUT_CYCLES
//     grant cycles, and o_timeout pulses for one cycle.
//     When it is undefined, no counter is built and o_timeout is tied to 0.
//
// Ports
//   i_clk       : clock, rising edge
//   i_reset     : asynchronous reset, active high
//   i_req       : per-channel request level, held until served
//   i_done      : release strobe from the current owner
//   o_grant     : registered one-hot grant, zero when idle
//   o_grant_id  : encoded index of o_grant, 0 when idle
//   o_valid     : registered |o_grant
//   o_timeout   : one-cycle pulse on a forced release
// ---------------------------------------------------------------------------

// Per-channel slice. Masks the current owner out of re-arbitration and taps
// the owner's own request for the abandon check.
module rra_lane (
  input  logic i_req,
  input  logic i_owner,
  output logic o_elig,
  output logic o_owner_req
);
  assign o_elig      = i_req & ~i_owner;
  assign o_owner_req = i_req &  i_owner;
endmodule

module round_robin_arbiter #(
  parameter  int CHANNELS       = 4,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int IDW            = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_req,
  input  logic                i_done,
  output logic [CHANNELS-1:0] o_grant,
  output logic [IDW-1:0]      o_grant_id,
  output logic                o_valid,
  output logic                o_timeout
);

  if (CHANNELS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("round_robin_arbiter: CHANNELS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [CHANNELS-1:0] r_grant, w_grant_nxt;
  logic [IDW-1:0]      r_id, w_id_nxt;
  logic [IDW-1:0]      r_ptr, w_ptr_nxt;
  logic                r_valid;

  logic [CHANNELS-1:0] w_elig, w_own_req;
  logic [IDW-1:0]      w_next_ptr, w_base, w_pick_id;
  logic                w_pick_any, w_owner_req, w_release, w_new_grant;
  logic                w_to_hit, w_to_fire;

  // (base + off) mod CHANNELS, where off < CHANNELS
  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= CHANNELS) s -= CHANNELS;
    return IDW'(s);
  endfunction

  // ---- per-channel lanes ----
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    rra_lane u_lane (
      .i_req       (i_req[g]),
      .i_owner     (r_grant[g]),
      .o_elig      (w_elig[g]),
      .o_owner_req (w_own_req[g])
    );
  end

  assign w_owner_req = |w_own_req;

  // Pointer after the current owner releases. Wraps from the last channel to 0.
  assign w_next_ptr = (r_id == IDW'(CHANNELS - 1)) ? '0 : r_id + 1'b1;

  // In IDLE the search starts at the stored pointer. On a release it starts
  // at the updated pointer in the same edge, so a back-to-back grant already
  // sees the new priority.
  assign w_base = (r_state == S_GRANT) ? w_next_ptr : r_ptr;

  // Search from the back of the order to the front. The last hit is then the
  // first eligible channel in priority order.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_id  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_elig[f_wrap(w_base, i)]) begin
        w_pick_any = 1'b1;
        w_pick_id  = f_wrap(w_base, i);
      end
    end
  end

  // ---- optional forced release ----
`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_timeout;

  assign w_to_hit  = (r_state == S_GRANT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // A release the owner asks for on the same edge (i_done, or a dropped
  // request) is an ordinary release, so it raises no timeout pulse.
  assign w_to_fire = w_to_hit & ~i_done & w_owner_req;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_new_grant || w_release) w_cnt_nxt = '0;
    else if (r_state == S_GRANT)  w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_to_fire;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_to_hit  = 1'b0;
  assign w_to_fire = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign w_release   = (r_state == S_GRANT) && (i_done || !w_owner_req || w_to_hit);
  assign w_new_grant = w_pick_any && ((r_state == S_IDLE) || w_release);

  // ---- FSM: state register ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_any)                 w_state_nxt = S_GRANT;
      S_GRANT: if (w_release && !w_pick_any)   w_state_nxt = S_IDLE;
      default:                                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: output / datapath next values ----
  always_comb begin
    w_grant_nxt = r_grant;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    if (r_state == S_IDLE || w_release) begin
      w_grant_nxt = '0;
      w_id_nxt    = '0;
    end
    // The pointer moves only on a release, never on a grant.
    if (w_release) w_ptr_nxt = w_next_ptr;
    if (w_new_grant) begin
      w_grant_nxt            = '0;
      w_grant_nxt[w_pick_id] = 1'b1;
      w_id_nxt               = w_pick_id;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_grant <= w_grant_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= |w_grant_nxt;
    end
  end

  assign o_grant    = r_grant;
  assign o_grant_id = r_id;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int T     = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int T     = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic       o_valid, o_timeout;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       to;
  } exp_t;

  exp_t sb[$];
  exp_t e, obs;
  int   n_err = 0;
  int   n_chk = 0;

  round_robin_arbiter #(.CHANNELS(4), .TIMEOUT_CYCLES(T)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_done     (done),
    .o_grant    (o_grant),
    .o_grant_id (o_grant_id),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] g, input logic to);
    exp_t x;
    x.g  = g;
    x.id = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) x.id = 2'(k);
    x.v  = |g;
    x.to = to;
    return x;
  endfunction

  function automatic int m_pick(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; done = 1'b0;
    #2;
    sb.push_back(mk(4'b0000, 1'b0));
    e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
    if (obs !== e) begin n_err++; $display("FAIL reset_async: got %b expected %b", obs, e); end
    for (int c = 0; c < 3; c++) begin
      sb.push_back(mk(4'b0000, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL reset_held[%0d]: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_single_grant();
    logic [3:0] rq [9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       dn [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] eg [9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req = rq[c]; done = dn[c];
      sb.push_back(mk(eg[c], 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL single_grant[%0d]: got %b expected %b", c, obs, e); end
    end
    done = 1'b0;
  endtask

  task automatic test_rotation();
    logic       dn [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] eg [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req = 4'hF; done = dn[c];
      sb.push_back(mk(eg[c], 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL rotation[%0d]: got %b expected %b", c, obs, e); end
    end
    done = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] rq [6] = '{4'h8, 4'h9, 4'h0, 4'h8, 4'h8, 4'h8};
    logic       dn [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] eg [6] = '{4'h8, 4'h1, 4'h0, 4'h8, 4'h0, 4'h8};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req = rq[c]; done = dn[c];
      sb.push_back(mk(eg[c], 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL wrap[%0d]: got %b expected %b", c, obs, e); end
    end
    done = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    sb.push_back(mk(4'b0010, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
    if (obs !== e) begin n_err++; $display("FAIL midreset_pre: got %b expected %b", obs, e); end
    #3; rst = 1'b1; #1;
    sb.push_back(mk(4'b0000, 1'b0));
    e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
    if (obs !== e) begin n_err++; $display("FAIL midreset_async: got %b expected %b", obs, e); end
    @(posedge clk); #1;
    req = 4'hF; rst = 1'b0;
    sb.push_back(mk(4'b0001, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
    if (obs !== e) begin n_err++; $display("FAIL midreset_restart: got %b expected %b", obs, e); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 4'b0010; done = 1'b0;
    n = TO_EN ? 10 : 110;
    for (int c = 0; c < n; c++) begin
      if (TO_EN && c == T)          sb.push_back(mk(4'b0000, 1'b1));
      else                          sb.push_back(mk(4'b0010, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL timeout[%0d]: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_random();
    int         m_owner, m_ptr, m_cnt, p;
    logic [3:0] mreq, g;
    logic       hit, rel, to;
    do_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 4) != 0) req[m_owner] = 1'b1;
      done = ($urandom_range(0, 3) == 0);
      to   = 1'b0;
      if (m_owner < 0) begin
        p = m_pick(req, m_ptr);
        if (p >= 0) begin m_owner = p; m_cnt = 0; end
      end else begin
        hit = TO_EN && (m_cnt == T - 1);
        rel = done || !req[m_owner] || hit;
        if (rel) begin
          to      = hit && !done && req[m_owner];
          m_ptr   = (m_owner + 1) % 4;
          mreq    = req;
          mreq[m_owner] = 1'b0;
          m_owner = m_pick(mreq, m_ptr);
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
      g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      sb.push_back(mk(g, to));
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {o_grant, o_grant_id, o_valid, o_timeout}; n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL random[%0d]: got %b expected %b", c, obs, e); end
    end
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
